// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and coefficient addresses for the
// fir_filter sequencer.
package fir_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAPS  = 3;
  localparam int DEF_LAT   = 1;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_W1 = 2'd0;
  localparam logic [1:0] ADDR_W2 = 2'd1;
  localparam logic [1:0] ADDR_W3 = 2'd2;

endpackage

// File: rtl/fir_filter.sv
// 3-tap unsigned FIR datapath. The result reflects the fir_in value set one
// edge earlier, and is truncated to 2*WIDTH bits.
module fir_filter
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   fir_in,
  input  logic [WIDTH-1:0]   w_1,
  input  logic [WIDTH-1:0]   w_2,
  input  logic [WIDTH-1:0]   w_3,
  output logic [2*WIDTH-1:0] fir_out
);

  logic [WIDTH-1:0]   x1_q, x2_q;
  logic [2*WIDTH-1:0] acc_d, acc_q;

  assign acc_d = ({{WIDTH{1'b0}}, w_1} * {{WIDTH{1'b0}}, fir_in})
               + ({{WIDTH{1'b0}}, w_2} * {{WIDTH{1'b0}}, x1_q})
               + ({{WIDTH{1'b0}}, w_3} * {{WIDTH{1'b0}}, x2_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q  <= '0;
      x2_q  <= '0;
      acc_q <= '0;
    end else begin
      x1_q  <= fir_in;
      x2_q  <= x1_q;
      acc_q <= acc_d;
    end
  end

  assign fir_out = acc_q;

endmodule

// File: rtl/fir_tag_pipe.sv
// Valid-tag delay line that keeps m_valid aligned with the filter result
// of the sample that produced it.
module fir_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_i,
  output logic tag_o
);

  logic [DEPTH-1:0] pipe_q;

  // Shift form works for DEPTH == 1 as well as deeper pipes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | DEPTH'(tag_i);
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_ctrl.sv
// Sequencer for fir_filter: sample intake with zero-stuffing, shadow/active
// coefficients, zero-drain before coefficient swaps, and output tagging.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAPS  = DEF_TAPS,
  parameter int LAT   = DEF_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [WIDTH-1:0]   cfg_data,
  input  logic               cfg_commit,
  input  logic               start,
  input  logic               stop,
  input  logic               s_valid,
  input  logic [WIDTH-1:0]   s_data,
  output logic               s_ready,
  output logic [WIDTH-1:0]   fir_in,
  output logic [WIDTH-1:0]   w_1,
  output logic [WIDTH-1:0]   w_2,
  output logic [WIDTH-1:0]   w_3,
  input  logic [2*WIDTH-1:0] fir_out,
  output logic               m_valid,
  output logic [2*WIDTH-1:0] m_data,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int DRAIN_LEN = TAPS + LAT;
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             pend_commit_q, pend_commit_d;
  logic             pend_stop_q, pend_stop_d;
  logic             load_active;
  logic [WIDTH-1:0] sh1_q, sh2_q, sh3_q;
  logic [WIDTH-1:0] w1_q, w2_q, w3_q;
  logic [WIDTH-1:0] fir_in_q;
  logic             tag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             clr_cnt;

  assign s_ready = (state_q == ST_RUN);
  assign busy    = (state_q != ST_IDLE);
  assign accept  = s_valid && s_ready;
  assign clr_cnt = (state_q == ST_IDLE) && start;

  // A commit from IDLE also raises pend_stop so LOAD returns to IDLE
  // instead of starting a stream nobody asked for.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    pend_commit_d = pend_commit_q;
    pend_stop_d   = pend_stop_q;
    load_active   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (cfg_commit) begin
          state_d       = ST_LOAD;
          pend_commit_d = 1'b1;
          pend_stop_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_commit || stop) begin
          state_d       = ST_DRAIN;
          drain_d       = DCW'(DRAIN_LEN - 1);
          pend_commit_d = pend_commit_q | cfg_commit;
          pend_stop_d   = pend_stop_q | stop;
        end
      end
      ST_DRAIN: begin
        pend_commit_d = pend_commit_q | cfg_commit;
        pend_stop_d   = pend_stop_q | stop;
        if (drain_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_LOAD: begin
        load_active   = pend_commit_q;
        pend_commit_d = 1'b0;
        pend_stop_d   = 1'b0;
        state_d       = pend_stop_q ? ST_IDLE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      drain_q       <= '0;
      pend_commit_q <= 1'b0;
      pend_stop_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      pend_commit_q <= pend_commit_d;
      pend_stop_q   <= pend_stop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1_q <= '0;
      sh2_q <= '0;
      sh3_q <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_W1: sh1_q <= cfg_data;
        ADDR_W2: sh2_q <= cfg_data;
        ADDR_W3: sh3_q <= cfg_data;
        default: ;
      endcase
    end
  end

  // Reads the registered shadow, so a same-cycle write lands after the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_q <= '0;
      w2_q <= '0;
      w3_q <= '0;
    end else if (load_active) begin
      w1_q <= sh1_q;
      w2_q <= sh2_q;
      w3_q <= sh3_q;
    end
  end

  // Every cycle is a sample slot; idle slots feed zeros with no tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_in_q <= '0;
      tag_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fir_in_q <= accept ? s_data : '0;
      tag_q    <= accept;
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  fir_tag_pipe #(
    .DEPTH(LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_q),
    .tag_o (m_valid)
  );

  assign fir_in     = fir_in_q;
  assign w_1        = w1_q;
  assign w_2        = w2_q;
  assign w_3        = w3_q;
  assign m_data     = fir_out;
  assign sample_cnt = cnt_q;

endmodule
